histogram: RTL and testbench
============================

HISTOGRAM -- requirements
Module: histogram

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving pixel width; the module has 2^DATA_WIDTH bins.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 18, giving the width of each bin counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port VSYNC, input, 1 bit: frame sync; a rising edge ends the frame.
REQ-006 The module SHALL have port DataEn, input, 1 bit: PixelData is valid this cycle.
REQ-007 The module SHALL have port PixelData, input, DATA_WIDTH bits: pixel value, used as the bin index.
REQ-008 The module SHALL have port Busy, output, 1 bit: a clear/readout sweep is in progress.
REQ-009 The module SHALL have port HistValid, output, 1 bit: HistBin and HistCount are valid this cycle.
REQ-010 The module SHALL have port HistBin, output, DATA_WIDTH bits: bin index being read out.
REQ-011 The module SHALL have port HistCount, output, CNT_WIDTH bits: final count of HistBin.

Function
REQ-012 Outside a sweep, each cycle with DataEn=1 SHALL add exactly 1 to bin[PixelData].
REQ-013 Accumulation SHALL be a 2-stage read-modify-write: read on the sampling cycle, write the incremented value on the next cycle.
REQ-014 Back-to-back samples of the same value (runs of any length) SHALL have the in-flight write forwarded, so no increment is lost.
REQ-015 Interleaved values (A,B,A) SHALL also be counted exactly.
REQ-016 Each bin SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-017 DataEn=0 SHALL leave all bins unchanged; PixelData is then don't-care.
REQ-018 VSYNC SHALL be registered; a 0->1 transition with Busy=0 SHALL start a readout sweep on the next cycle, after the pending pipeline write completes.
REQ-019 A readout sweep SHALL last 2^DATA_WIDTH consecutive cycles with Busy=1, emitting bins in order 0..2^DATA_WIDTH-1.
REQ-020 Each sweep cycle SHALL assert HistValid=1 with HistBin=i and HistCount=bin[i], then clear bin[i] to 0.
REQ-021 Busy and HistValid SHALL fall together after bin 2^DATA_WIDTH-1.
REQ-022 DataEn samples while Busy=1 SHALL be discarded.
REQ-023 VSYNC edges while Busy=1 SHALL be ignored; they are not queued.
REQ-024 HistValid SHALL be 0 whenever Busy=0.
REQ-025 HistBin and HistCount SHALL be held at 0 whenever HistValid=0.
REQ-026 An unconnected or X VSYNC SHALL never be treated as a rising edge; the edge detector requires a registered 0 followed by a 1.

Reset
REQ-027 With rst=1 at a clock edge, Busy, HistValid, HistBin, HistCount, the pipeline and the VSYNC register SHALL go to 0 on that edge.
REQ-028 On rst deassertion, a clear-only sweep SHALL run for 2^DATA_WIDTH cycles, zeroing every bin, with Busy=1 and HistValid=0.
REQ-029 Reset asserted mid-accumulation or mid-sweep SHALL abort the operation and restart the clear sweep.
REQ-030 Bins SHALL start at 0 after that clear sweep.

Structure
REQ-031 Bin storage SHALL be a simple dual-port RAM, 2^DATA_WIDTH x CNT_WIDTH, one read and one write port, synchronous read.
REQ-032 The RAM SHALL be a sub-module named hist_ram.
REQ-033 The sweep control SHALL be an FSM with states IDLE, CLEAR and READOUT.
REQ-034 The FSM state encoding and the saturation constant SHALL live in a shared package hist_pkg.

Verification
REQ-035 Reset test: rst for 2 cycles, then release -> Busy=1 for exactly 256 cycles with HistValid=0 throughout.
REQ-036 Accumulation test: DataEn=1 with pixels 0,1,2,3,2,4,4,5,5,5,0,6,6,6,6,1,1, then a VSYNC pulse -> readout gives bin0=2, bin1=3, bin2=2, bin3=1, bin4=2, bin5=3, bin6=4, all other bins 0, total 17.
REQ-037 Clear-after-readout test: repeat the REQ-036 readout without new data -> all 256 bins read 0.
REQ-038 Saturation test: CNT_WIDTH=4 and 20 consecutive pixels of value 7 -> bin7=15.
REQ-039 Busy-discard test: DataEn=1 with pixel 9 during a sweep, then a second VSYNC pulse -> bin9=0 in the next readout.
REQ-040 Mid-sweep reset test: rst asserted at sweep cycle 100 -> HistValid drops on the next cycle, a full 256-cycle clear sweep follows, and a subsequent readout is all zeros.

Source files
------------

// File: rtl/hist_pkg.sv
// hist_pkg: sweep FSM encoding and the all-ones source for bin saturation
package hist_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, READOUT} state_e;
    localparam int MAX_CNT_WIDTH = 32;
    localparam logic [MAX_CNT_WIDTH-1:0] SAT_ONES = '1;
endpackage

// File: rtl/hist_ram.sv
// hist_ram: simple dual-port bin store, synchronous read returning pre-write data
module hist_ram #(
    parameter int AW = 8,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q;
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_q <= mem[ra];
    end
    assign rd = rd_q;
endmodule

// File: rtl/histogram.sv
// histogram: per-frame pixel histogram with forwarded RMW accumulation and clear/readout sweeps
module histogram
    import hist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  VSYNC,
    input  logic                  DataEn,
    input  logic [DATA_WIDTH-1:0] PixelData,
    output logic                  Busy,
    output logic                  HistValid,
    output logic [DATA_WIDTH-1:0] HistBin,
    output logic [CNT_WIDTH-1:0]  HistCount
);
    localparam logic [CNT_WIDTH-1:0]  SAT_MAX = SAT_ONES[CNT_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] LAST    = '1;

    state_e                state_q, state_d;
    logic                  init_q, init_d, vsync_q;
    logic                  p1_vld_q, p1_vld_d, lw_en_q;
    logic [DATA_WIDTH-1:0] idx_q, idx_d, p1_addr_q, p1_addr_d, lw_addr_q;
    logic [DATA_WIDTH-1:0] rd_addr, wr_addr, fwd_addr;
    logic [CNT_WIDTH-1:0]  lw_data_q, rd_data, base, wr_data;
    logic                  wr_en;

    hist_ram #(.AW(DATA_WIDTH), .DW(CNT_WIDTH)) u_ram (
        .clk(clk), .we(wr_en), .wa(wr_addr), .wd(wr_data), .ra(rd_addr), .rd(rd_data)
    );

    // The write that landed on the same edge as the read is invisible to it; forward it.
    assign fwd_addr = (state_q == READOUT) ? idx_q : p1_addr_q;
    assign base     = (lw_en_q && lw_addr_q == fwd_addr) ? lw_data_q : rd_data;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        init_d    = init_q;
        p1_vld_d  = 1'b0;
        p1_addr_d = PixelData;
        rd_addr   = PixelData;
        wr_en     = p1_vld_q;
        wr_addr   = p1_addr_q;
        wr_data   = (base == SAT_MAX) ? base : base + 1'b1;
        if (state_q == IDLE) begin
            if (init_q) begin
                state_d = CLEAR;
                init_d  = 1'b0;
                idx_d   = '0;
            end else if (VSYNC && !vsync_q) begin
                state_d = READOUT;
                idx_d   = '0;
                rd_addr = '0;
            end else begin
                p1_vld_d = DataEn;
            end
        end else begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = '0;
            rd_addr = idx_q + 1'b1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            init_q    <= 1'b1;
            idx_q     <= '0;
            vsync_q   <= 1'b0;
            p1_vld_q  <= 1'b0;
            p1_addr_q <= '0;
            lw_en_q   <= 1'b0;
            lw_addr_q <= '0;
            lw_data_q <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            idx_q     <= idx_d;
            vsync_q   <= VSYNC;
            p1_vld_q  <= p1_vld_d;
            p1_addr_q <= p1_addr_d;
            lw_en_q   <= wr_en;
            lw_addr_q <= wr_addr;
            lw_data_q <= wr_data;
        end
    end

    assign Busy      = state_q != IDLE;
    assign HistValid = state_q == READOUT;
    assign HistBin   = HistValid ? idx_q : '0;
    assign HistCount = HistValid ? base : '0;
endmodule

// File: tb/tb_histogram.sv
// tb_histogram: directed checks of clear, accumulate, saturate, discard and mid-sweep reset
module tb_histogram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        VSYNC = 1'b0;
    logic        DataEn = 1'b0;
    logic [7:0]  PixelData = '0;
    logic        Busy, HistValid, s_busy, s_valid;
    logic [7:0]  HistBin, s_bin;
    logic [17:0] HistCount;
    logic [3:0]  s_count;

    int total = 0;
    int bad = 0;
    int n_read, order_err, n_busy, hv_busy, sum;
    logic [17:0] got [256];
    logic [3:0]  got_s [256];
    int px [17] = '{0, 1, 2, 3, 2, 4, 4, 5, 5, 5, 0, 6, 6, 6, 6, 1, 1};
    int exp_acc [7] = '{2, 3, 2, 1, 2, 3, 4};

    always #5 clk = ~clk;

    histogram dut (
        .clk(clk), .rst(rst), .VSYNC(VSYNC), .DataEn(DataEn), .PixelData(PixelData),
        .Busy(Busy), .HistValid(HistValid), .HistBin(HistBin), .HistCount(HistCount)
    );

    histogram #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .VSYNC(VSYNC), .DataEn(DataEn), .PixelData(PixelData),
        .Busy(s_busy), .HistValid(s_valid), .HistBin(s_bin), .HistCount(s_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sweep_count();
        n_busy = 0;
        hv_busy = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (Busy === 1'b1) begin
                n_busy++;
                if (HistValid !== 1'b0) hv_busy++;
            end else if (n_busy > 0) begin
                break;
            end
        end
    endtask

    // Pulses VSYNC and records one readout; optionally feeds pixel 9 and a stray VSYNC mid-sweep.
    task automatic collect(input bit disturb);
        int i;
        for (int b = 0; b < 256; b++) begin
            got[b] = 'x;
            got_s[b] = 'x;
        end
        order_err = 0;
        i = 0;
        VSYNC = 1'b1;
        step();
        VSYNC = 1'b0;
        while (HistValid === 1'b1 && i < 300) begin
            got[HistBin] = HistCount;
            got_s[s_bin] = s_count;
            if (HistBin !== i[7:0] || Busy !== 1'b1) order_err++;
            DataEn = disturb;
            PixelData = 8'd9;
            VSYNC = disturb && (i >= 50 && i < 52);
            i++;
            step();
        end
        DataEn = 1'b0;
        VSYNC = 1'b0;
        n_read = i;
    endtask

    function automatic int sum_all();
        int s = 0;
        for (int b = 0; b < 256; b++) s += int'(got[b]);
        return s;
    endfunction

    initial begin
        step();
        step();
        chk("rst_busy", Busy, 0);
        chk("rst_valid", HistValid, 0);
        chk("rst_bin", HistBin, 0);
        chk("rst_count", HistCount, 0);
        rst = 1'b0;
        sweep_count();
        chk("clear_len", n_busy, 256);
        chk("clear_hv", hv_busy, 0);
        chk("idle_busy", Busy, 0);

        foreach (px[k]) begin
            DataEn = 1'b1;
            PixelData = px[k][7:0];
            step();
        end
        DataEn = 1'b0;
        step();
        collect(1'b0);
        chk("acc_len", n_read, 256);
        chk("acc_order", order_err, 0);
        foreach (exp_acc[b]) chk($sformatf("acc_bin%0d", b), got[b], exp_acc[b]);
        sum = 0;
        for (int b = 7; b < 256; b++) sum += int'(got[b]);
        chk("acc_rest", sum, 0);
        chk("acc_total", sum_all(), 17);
        chk("post_valid", HistValid, 0);
        chk("post_bin", HistBin, 0);
        chk("post_count", HistCount, 0);

        collect(1'b0);
        chk("reclear_len", n_read, 256);
        chk("reclear_total", sum_all(), 0);

        for (int k = 0; k < 20; k++) begin
            DataEn = 1'b1;
            PixelData = 8'd7;
            step();
        end
        DataEn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            PixelData = 8'd7;
            step();
        end
        collect(1'b1);
        chk("sat_len", n_read, 256);
        chk("sat_bin7_wide", got[7], 20);
        chk("sat_bin7_narrow", got_s[7], 15);
        chk("sat_total", sum_all(), 20);
        step();
        step();
        chk("stray_vsync_busy", Busy, 0);

        collect(1'b0);
        chk("discard_len", n_read, 256);
        chk("discard_bin9", got[9], 0);
        chk("discard_total", sum_all(), 0);

        for (int k = 0; k < 2; k++) begin
            DataEn = 1'b1;
            PixelData = 8'd3;
            step();
        end
        DataEn = 1'b0;
        step();
        VSYNC = 1'b1;
        step();
        VSYNC = 1'b0;
        for (int k = 0; k < 100; k++) step();
        chk("mid_bin", HistBin, 100);
        rst = 1'b1;
        step();
        chk("mid_valid", HistValid, 0);
        chk("mid_busy", Busy, 0);
        rst = 1'b0;
        sweep_count();
        chk("mid_clear_len", n_busy, 256);
        chk("mid_clear_hv", hv_busy, 0);
        collect(1'b0);
        chk("mid_read_len", n_read, 256);
        chk("mid_read_total", sum_all(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
